// File: rtl/sm3_pad_core_if.sv
// sm3_pad_core_if: message-in / padded-block-out bundle for sm3_pad_core.
// Handshake rules:
// - An input beat transfers on a rising edge when msg_inpt_vld_i & msg_inpt_rdy_o.
// - An output word transfers on a rising edge when pad_otpt_vld_o & pad_otpt_ena_i.
// - A valid output word that is not enabled stays stable until it transfers.
interface sm3_pad_core_if #(
    parameter int INPT_DW = 32
);
    logic [INPT_DW-1:0]   msg_inpt_d_i;
    logic [INPT_DW/8-1:0] msg_inpt_vld_byte_i;
    logic                 msg_inpt_vld_i;
    logic                 msg_inpt_lst_i;
    logic                 msg_inpt_rdy_o;
    logic                 pad_otpt_ena_i;
    logic [INPT_DW-1:0]   pad_otpt_d_o;
    logic                 pad_otpt_vld_o;
    logic                 pad_otpt_lst_o;

    // Environment side: drives the message stream and the downstream enable.
    modport master (
        output msg_inpt_d_i,
        output msg_inpt_vld_byte_i,
        output msg_inpt_vld_i,
        output msg_inpt_lst_i,
        output pad_otpt_ena_i,
        input  msg_inpt_rdy_o,
        input  pad_otpt_d_o,
        input  pad_otpt_vld_o,
        input  pad_otpt_lst_o
    );

    // Padder side.
    modport slave (
        input  msg_inpt_d_i,
        input  msg_inpt_vld_byte_i,
        input  msg_inpt_vld_i,
        input  msg_inpt_lst_i,
        input  pad_otpt_ena_i,
        output msg_inpt_rdy_o,
        output pad_otpt_d_o,
        output pad_otpt_vld_o,
        output pad_otpt_lst_o
    );
endinterface

// File: rtl/sm3_pad_core.sv
// sm3_pad_core: SM3 message padder. Forwards a byte-granular message stream as
// 512-bit blocks, appending the '1' marker byte, zero fill and the 64-bit
// big-endian bit length. One register stage between input and output.
// Width select: define SM3_INPT_DW_64 for a 64-bit datapath (default 32).
// Optional feature: define SM3_PAD_ERR_CHK_EN to add the sticky pad_err_o flag
// for malformed byte-valid patterns.
module sm3_pad_core #(
`ifdef SM3_INPT_DW_64
    parameter int INPT_DW = 64
`else
    parameter int INPT_DW = 32
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    sm3_pad_core_if.slave bus,
    output logic [1:0]    dbg_state_o
`ifdef SM3_PAD_ERR_CHK_EN
    ,
    output logic          pad_err_o
`endif
);
    localparam int NB        = INPT_DW / 8;          // bytes per word
    localparam int BLK_WN    = 512 / INPT_DW;        // words per block
    localparam int WI_W      = $clog2(BLK_WN);
    localparam int KW        = $clog2(NB + 1);       // width of a byte count per beat
    localparam int LEN_WN    = 64 / INPT_DW;         // words taken by the length field
    localparam int LEN_START = BLK_WN - LEN_WN;      // first word index of the length slot
    localparam logic [INPT_DW-1:0] MARK_WORD = INPT_DW'(8'h80) << (INPT_DW - 8);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAD  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WI_W-1:0]     wi_q, wi_d;             // index of the next word emitted in the block
    logic [60:0]         byte_cnt_q, byte_cnt_d; // message length in bytes
    logic                pend_80_q, pend_80_d;   // marker byte still owed as a whole word
    logic                ovf_q, ovf_d;           // marker landed in the length slot: length goes in the next block
    logic [INPT_DW-1:0]  out_d_q, out_d_d;
    logic                out_vld_q, out_vld_d;
    logic                out_lst_q, out_lst_d;

    logic [KW-1:0]       beat_k;
    logic [INPT_DW-1:0]  beat_msk;
    logic [INPT_DW-1:0]  beat_word;
    logic [63:0]         bit_len;
    logic [INPT_DW-1:0]  len_word;
    logic                rdy;
    logic                acc;
    logic                emit;
    logic [INPT_DW-1:0]  emit_word;
    logic                emit_lst;
    logic                mark_here;

    // Decode the incoming beat: valid-byte count, lane masking and marker insertion on a partial last beat.
    always_comb begin
        beat_k   = '0;
        beat_msk = '0;
        for (int j = 0; j < NB; j++) begin
            if (bus.msg_inpt_vld_byte_i[NB-1-j]) begin
                beat_k = beat_k + KW'(1);
                beat_msk[INPT_DW-1-8*j -: 8] = 8'hFF;
            end
        end
        beat_word = bus.msg_inpt_d_i & beat_msk;
        if (bus.msg_inpt_lst_i && (beat_k != '0) && (beat_k != KW'(NB))) begin
            beat_word = beat_word | (MARK_WORD >> (8 * beat_k));
        end
    end

    // Length field words: high half first in the 32-bit build, whole field in the 64-bit build.
    always_comb begin
        bit_len  = {byte_cnt_q, 3'b000};
        len_word = bit_len[((wi_q == WI_W'(BLK_WN - 1)) ? 0 : (64 - INPT_DW)) +: INPT_DW];
    end

    // Next-state, word generation and output-register update.
    always_comb begin
        state_d    = state_q;
        wi_d       = wi_q;
        byte_cnt_d = byte_cnt_q;
        pend_80_d  = pend_80_q;
        ovf_d      = ovf_q;
        out_d_d    = out_d_q;
        out_vld_d  = out_vld_q;
        out_lst_d  = out_lst_q;
        rdy        = 1'b0;
        acc        = 1'b0;
        emit       = 1'b0;
        emit_word  = '0;
        emit_lst   = 1'b0;
        mark_here  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_DATA;
            end
            ST_DATA: begin
                rdy = bus.pad_otpt_ena_i;
                acc = rdy && bus.msg_inpt_vld_i;
                if (acc) begin
                    byte_cnt_d = byte_cnt_q + 61'(beat_k);
                    emit       = (beat_k != '0);
                    emit_word  = beat_word;
                    if (bus.msg_inpt_lst_i) begin
                        state_d   = ST_PAD;
                        // Empty or full last beat: the marker needs its own word.
                        pend_80_d = (beat_k == '0) || (beat_k == KW'(NB));
                        mark_here = !pend_80_d;
                    end
                end
            end
            ST_PAD: begin
                if (bus.pad_otpt_ena_i) begin
                    emit = 1'b1;
                    if (pend_80_q) begin
                        emit_word = MARK_WORD;
                        pend_80_d = 1'b0;
                        mark_here = 1'b1;
                    end else if (!ovf_q && (wi_q >= WI_W'(LEN_START))) begin
                        emit_word = len_word;
                        if (wi_q == WI_W'(BLK_WN - 1)) begin
                            emit_lst   = 1'b1;
                            state_d    = ST_DATA;
                            byte_cnt_d = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A marker in the length slot pushes the length into an extra block;
        // wrapping into a fresh block clears that condition.
        if (mark_here && (wi_q >= WI_W'(LEN_START))) begin
            ovf_d = 1'b1;
        end
        if (emit && (wi_q == WI_W'(BLK_WN - 1))) begin
            ovf_d = 1'b0;
        end
        if (emit) begin
            wi_d = wi_q + WI_W'(1);
        end
        // Output register only moves while downstream is enabled.
        if (bus.pad_otpt_ena_i) begin
            out_d_d   = emit_word;
            out_vld_d = emit;
            out_lst_d = emit_lst;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wi_q       <= '0;
            byte_cnt_q <= '0;
            pend_80_q  <= 1'b0;
            ovf_q      <= 1'b0;
            out_d_q    <= '0;
            out_vld_q  <= 1'b0;
            out_lst_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wi_q       <= wi_d;
            byte_cnt_q <= byte_cnt_d;
            pend_80_q  <= pend_80_d;
            ovf_q      <= ovf_d;
            out_d_q    <= out_d_d;
            out_vld_q  <= out_vld_d;
            out_lst_q  <= out_lst_d;
        end
    end

    assign bus.msg_inpt_rdy_o = rdy;
    assign bus.pad_otpt_d_o   = out_d_q;
    assign bus.pad_otpt_vld_o = out_vld_q;
    assign bus.pad_otpt_lst_o = out_lst_q;
    assign dbg_state_o        = state_q;

`ifdef SM3_PAD_ERR_CHK_EN
    logic pad_err_q, pad_err_d;
    logic noncontig;

    // Flag short non-last beats and byte valids with a gap below the MSB run.
    always_comb begin
        noncontig = 1'b0;
        for (int j = 1; j < NB; j++) begin
            if (bus.msg_inpt_vld_byte_i[NB-1-j] && !bus.msg_inpt_vld_byte_i[NB-j]) begin
                noncontig = 1'b1;
            end
        end
        pad_err_d = pad_err_q;
        if (acc && ((!bus.msg_inpt_lst_i && (bus.msg_inpt_vld_byte_i != '1)) || noncontig)) begin
            pad_err_d = 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pad_err_q <= 1'b0;
        end else begin
            pad_err_q <= pad_err_d;
        end
    end

    assign pad_err_o = pad_err_q;
`endif
endmodule

// File: tb/tb_sm3_pad_core.sv
// tb_sm3_pad_core: randomized message stream against a byte-level SM3 padding
// model; a negedge monitor pops expected words as the padder hands them off.
module tb_sm3_pad_core;
`ifdef SM3_INPT_DW_64
    localparam int DW = 64;
`else
    localparam int DW = 32;
`endif
    localparam int NB = DW / 8;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] dbg_state;
`ifdef SM3_PAD_ERR_CHK_EN
    logic pad_err;
`endif

    // Clock
    always #5 clk = ~clk;

    sm3_pad_core_if #(.INPT_DW(DW)) bus ();

    sm3_pad_core #(.INPT_DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
`ifdef SM3_PAD_ERR_CHK_EN
        ,
        .pad_err_o   (pad_err)
`endif
    );

    // Scoreboard state
    logic [DW-1:0] exp_q[$];
    logic          exp_lst_q[$];
    int            n_chk  = 0;
    int            n_fail = 0;
    logic          ena_rand = 1'b0;
    logic          ena_lo   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: padded byte stream per the standard, chopped into words.
    task automatic model_push(input bq_t msg);
        logic [7:0]    p[$];
        logic [63:0]   bl;
        logic [DW-1:0] word;
        int            nw;
        p  = msg;
        bl = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        nw = p.size() / NB;
        for (int w = 0; w < nw; w++) begin
            word = '0;
            for (int b = 0; b < NB; b++) word = {word[DW-9:0], p[w*NB+b]};
            exp_q.push_back(word);
            exp_lst_q.push_back(w == nw - 1);
        end
    endtask

    // Downstream enable driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ena_lo)        bus.pad_otpt_ena_i = 1'b0;
            else if (ena_rand) bus.pad_otpt_ena_i = ($urandom_range(0, 3) != 0);
            else               bus.pad_otpt_ena_i = 1'b1;
        end
    end

    // Driver: present one beat and hold it until accepted (bounded).
    task automatic send_beat(input logic [DW-1:0] d, input logic [NB-1:0] vb, input logic lst);
        logic acc;
        int   budget;
        bus.msg_inpt_d_i        = d;
        bus.msg_inpt_vld_byte_i = vb;
        bus.msg_inpt_lst_i      = lst;
        bus.msg_inpt_vld_i      = 1'b1;
        acc    = 1'b0;
        budget = 0;
        while (!acc && budget < 2000) begin
            @(negedge clk);
            acc = bus.msg_inpt_rdy_o;
            @(posedge clk);
            #1;
            budget++;
        end
        check("beat_accept", 64'(acc), 64'd1);
        bus.msg_inpt_vld_i = 1'b0;
        bus.msg_inpt_lst_i = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_word();
        return DW'({$urandom(), $urandom()});
    endfunction

    // Send a whole message; invalid lanes carry garbage. Optionally close an
    // aligned message with an empty last beat.
    task automatic send_msg(input bq_t msg, input bit empty_lst);
        int            len;
        logic [DW-1:0] d;
        logic [NB-1:0] vb;
        logic          last;
        len = msg.size();
        model_push(msg);
        if (len == 0) begin
            send_beat(rand_word(), '0, 1'b1);
        end else begin
            for (int s = 0; s < len; s += NB) begin
                d  = rand_word();
                vb = '0;
                for (int b = 0; b < NB; b++) begin
                    if (s + b < len) begin
                        d[DW-1-8*b -: 8] = msg[s+b];
                        vb[NB-1-b]       = 1'b1;
                    end
                end
                last = (s + NB >= len);
                send_beat(d, vb, last && !(empty_lst && (len % NB == 0)));
            end
            if (empty_lst && (len % NB == 0)) send_beat(rand_word(), '0, 1'b1);
        end
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        check("rst_vld",   64'(bus.pad_otpt_vld_o), 64'd0);
        check("rst_data",  64'(bus.pad_otpt_d_o),   64'd0);
        check("rst_lst",   64'(bus.pad_otpt_lst_o), 64'd0);
        check("rst_rdy",   64'(bus.msg_inpt_rdy_o), 64'd0);
        check("rst_state", 64'(dbg_state),          64'd0);
    endtask

    // Monitor: compare each transferring word, and check held words stay stable.
    logic          held_v = 1'b0;
    logic [DW-1:0] held_d;
    logic          held_l;
    logic [DW-1:0] ew;
    logic          el;
    always @(negedge clk) begin
        if (rst_n) begin
            if (held_v) begin
                check("hold_vld",  64'(bus.pad_otpt_vld_o), 64'd1);
                check("hold_data", 64'(bus.pad_otpt_d_o),   64'(held_d));
                check("hold_lst",  64'(bus.pad_otpt_lst_o), 64'(held_l));
            end
            if (!bus.pad_otpt_ena_i) check("rdy_when_stalled", 64'(bus.msg_inpt_rdy_o), 64'd0);
            if (!bus.pad_otpt_vld_o) check("lst_without_vld", 64'(bus.pad_otpt_lst_o), 64'd0);
            if (bus.pad_otpt_vld_o && bus.pad_otpt_ena_i) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h, expected no word at %0t", bus.pad_otpt_d_o, $time);
                end else begin
                    ew = exp_q.pop_front();
                    el = exp_lst_q.pop_front();
                    check("word", 64'(bus.pad_otpt_d_o), 64'(ew));
                    check("word_lst", 64'(bus.pad_otpt_lst_o), 64'(el));
                end
            end
            held_v <= bus.pad_otpt_vld_o && !bus.pad_otpt_ena_i;
            held_d <= bus.pad_otpt_d_o;
            held_l <= bus.pad_otpt_lst_o;
        end else begin
            held_v <= 1'b0;
        end
    end

    // Stimulus sequence
    initial begin
        bq_t m;
        bus.msg_inpt_d_i        = '0;
        bus.msg_inpt_vld_byte_i = '0;
        bus.msg_inpt_vld_i      = 1'b0;
        bus.msg_inpt_lst_i      = 1'b0;
        bus.pad_otpt_ena_i      = 1'b1;

        // Reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 10-byte message from the reference example
        m = {8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h02};
        send_msg(m, 1'b0);
        // 8 bytes aligned
        m = {};
        for (int i = 0; i < 8; i++) m.push_back(8'(i + 1));
        send_msg(m, 1'b0);
        // 56 bytes aligned: length spills into a second block
        m = {};
        for (int i = 0; i < 56; i++) m.push_back(8'(i + 16));
        send_msg(m, 1'b0);
        // Empty message
        m = {};
        send_msg(m, 1'b0);

        // Random lengths and contents with random backpressure
        ena_rand = 1'b1;
        for (int n = 0; n < 20; n++) begin
            m = {};
            for (int i = $urandom_range(0, 140); i > 0; i--) m.push_back(8'($urandom_range(0, 255)));
            send_msg(m, 1'($urandom_range(0, 1)));
        end
        ena_rand = 1'b0;

        // Directed 3-cycle enable drop in the middle of a message
        m = {};
        for (int i = 0; i < 30; i++) m.push_back(8'($urandom_range(0, 255)));
        fork
            send_msg(m, 1'b0);
            begin
                repeat (3) @(posedge clk);
                ena_lo = 1'b1;
                repeat (3) @(posedge clk);
                ena_lo = 1'b0;
            end
        join

        // Reset in the middle of a message: partial words are discarded
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(DW'(32'hA5A5_0000 + 32'(i)));
            exp_lst_q.push_back(1'b0);
            send_beat(DW'(32'hA5A5_0000 + 32'(i)), '1, 1'b0);
        end
        ena_lo = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        exp_q.delete();
        exp_lst_q.delete();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        ena_lo = 1'b0;
        m = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_msg(m, 1'b0);

        // Drain
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain_remaining", 64'(exp_q.size()), 64'd0);
        repeat (4) @(posedge clk);
`ifdef SM3_PAD_ERR_CHK_EN
        check("pad_err_clean", 64'(pad_err), 64'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
